wb_initiator_arbiter: RTL
=========================

// Module: wb_initiator_arbiter
// PURPOSE
//  Round-robin arbiter that lets N Wishbone initiators share one target port.
//  Sits upstream of the wb_interconnect_1xN decoder, whose single t_* port it drives.
//  Holds the grant for a whole bus cycle (i_cyc high), so multi-beat and
//  read-modify-write sequences are not interleaved.
//  Bus-timeout watchdog returns err so a hung target cannot lock the bus.
// PARAMETERS
//  WB_ADDR_WIDTH   32   address width
//  WB_DATA_WIDTH   32   data width (multiple of 8)
//  N_INITIATORS    2    number of requesting initiators, >=2
//  TIMEOUT_CYCLES  255  stalled-strobe cycles before a forced err; 0 disables the watchdog
// PORTS
//  clock     in   1                 bus clock
//  reset     in   1                 synchronous, active-high reset
//  i_adr     in   N*WB_ADDR_WIDTH   initiator addresses, initiator k at [k*AW +: AW]
//  i_dat_w   in   N*WB_DATA_WIDTH   initiator write data
//  i_dat_r   out  N*WB_DATA_WIDTH   read data; t_dat_r copied to every slice
//  i_cyc     in   N                 per-initiator cycle (bus request)
//  i_stb     in   N                 per-initiator strobe
//  i_we      in   N                 per-initiator write enable
//  i_sel     in   N*WB_DATA_WIDTH/8 per-initiator byte selects
//  i_ack     out  N                 ack, routed to the granted initiator only
//  i_err     out  N                 err, routed to the granted initiator only
//  t_adr     out  WB_ADDR_WIDTH     to shared target/interconnect
//  t_dat_w   out  WB_DATA_WIDTH
//  t_dat_r   in   WB_DATA_WIDTH
//  t_cyc     out  1
//  t_stb     out  1
//  t_we      out  1
//  t_sel     out  WB_DATA_WIDTH/8
//  t_ack     in   1
//  t_err     in   1
//  gnt       out  N                 one-hot registered grant (status/debug)
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, gnt=0, rr_ptr=0, tmo_cnt=0.
//    All outputs 0 in the first cycle after reset; reset mid-cycle drops the grant at that edge.
//  - States:
//    - IDLE: t_cyc=t_stb=t_we=0, t_adr/t_dat_w/t_sel=0, i_ack=i_err=0.
//    - OWNED: t_* = combinational mux of the granted initiator's signals.
//  - IDLE->OWNED at the edge where any i_cyc=1. Winner = first requester searching
//    rr_ptr, rr_ptr+1, ... modulo N. gnt is registered, so the target sees the
//    request 1 cycle after i_cyc first rises (1-cycle arbitration latency).
//  - OWNED->IDLE at the edge where i_cyc[g]=0 (g = granted index). rr_ptr <= (g+1) mod N.
//    There is always one IDLE cycle between owners, even if others are already requesting.
//  - Only granted initiator g is connected:
//    - i_ack[g] = t_ack.
//    - i_err[g] = t_err | tmo_err.
//    - All other i_ack/i_err bits are 0. Non-granted initiators simply wait (no err).
//  - A cyc drop in the same cycle as ack is legal; that ack is still delivered.
//  - Watchdog (TIMEOUT_CYCLES>0), width $clog2(TIMEOUT_CYCLES+1):
//    - In OWNED with t_stb & !t_ack & !t_err, tmo_cnt increments.
//    - On ack, err, !t_stb or IDLE, tmo_cnt clears.
//    - When tmo_cnt==TIMEOUT_CYCLES: tmo_err=1 for exactly that cycle, t_stb is forced to 0
//      in that cycle, and tmo_cnt clears. t_ack in that same cycle is ignored.
//  - No starvation: with all N requesting continuously, grants rotate 0,1,..,N-1,0.
//  - Data path adds no registers; only gnt/state/rr_ptr/tmo_cnt are sequential.
// TESTING
//  1. Reset, single req: i_cyc[1]=i_stb[1]=1 at cycle 0 -> gnt=2'b10 and t_cyc=1 at cycle 1;
//     t_ack at cycle 3 -> i_ack=2'b10 at cycle 3, i_ack[0]=0 throughout.
//  2. Round robin: N=4, all i_cyc held, each cycle lasting 2 beats -> grant order 0,1,2,3,0,
//     one IDLE cycle between grants.
//  3. Hold: i_cyc[0] held across 3 acked beats while i_cyc[1]=1 -> gnt stays 01 until
//     i_cyc[0] falls, then IDLE for one cycle, then gnt=10.
//  4. Timeout: TIMEOUT_CYCLES=4, target never acks -> i_err[g] pulses 1 cycle on the 5th
//     stalled cycle, t_stb=0 that cycle, counter restarts.
//  5. Target err: t_err=1 -> i_err[g]=1 same cycle, other i_err=0, data copied to all i_dat_r.
//  6. Reset mid-OWNED -> next cycle gnt=0, t_cyc=0, rr_ptr=0; a later request from 1 is
//     granted normally.

Source files
------------

// File: rtl/wb_initiator_arbiter_if.sv
// Bus bundle between N Wishbone initiators and one shared target port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface wb_initiator_arbiter_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int N_INITIATORS  = 2
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int N  = N_INITIATORS;
    localparam int SW = WB_DATA_WIDTH / 8;

    logic [N*AW-1:0] i_adr;
    logic [N*DW-1:0] i_dat_w;
    logic [N*DW-1:0] i_dat_r;
    logic [N-1:0]    i_cyc;
    logic [N-1:0]    i_stb;
    logic [N-1:0]    i_we;
    logic [N*SW-1:0] i_sel;
    logic [N-1:0]    i_ack;
    logic [N-1:0]    i_err;

    logic [AW-1:0]   t_adr;
    logic [DW-1:0]   t_dat_w;
    logic [DW-1:0]   t_dat_r;
    logic            t_cyc;
    logic            t_stb;
    logic            t_we;
    logic [SW-1:0]   t_sel;
    logic            t_ack;
    logic            t_err;

    modport slave (
        input  i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel, t_dat_r, t_ack, t_err,
        output i_dat_r, i_ack, i_err, t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel
    );

    modport master (
        output i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel, t_dat_r, t_ack, t_err,
        input  i_dat_r, i_ack, i_err, t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel
    );
endinterface

// File: rtl/wb_initiator_arbiter.sv
// Round-robin arbiter: N Wishbone initiators share one target port, grant held for
// a whole bus cycle, with a stalled-strobe watchdog that forces err.
//
//  state | meaning
//  IDLE  | no owner; target side driven to 0, one cycle between owners
//  OWNED | initiator gidx owns the target; t_* muxed from its signals
module wb_initiator_arbiter #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_INITIATORS   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    wb_initiator_arbiter_if.slave   bus,
    output logic [N_INITIATORS-1:0] gnt
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int N  = N_INITIATORS;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = $clog2(N_INITIATORS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_ptr;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_err;
    logic          stalled;
    logic          found;
    int            idx;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && bus.i_cyc[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign next_ptr = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
    assign tmo_err  = (TIMEOUT_CYCLES > 0) && (state == OWNED) &&
                      (tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign stalled  = bus.i_stb[gidx] & ~bus.t_ack & ~bus.t_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (|bus.i_cyc) begin
                        state <= OWNED;
                        gidx  <= winner;
                        gnt   <= N'(1) << winner;
                    end
                end
                OWNED: begin
                    if (!bus.i_cyc[gidx]) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        rr_ptr  <= next_ptr;
                        tmo_cnt <= '0;
                    end else if ((TIMEOUT_CYCLES == 0) || tmo_err || !stalled) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // A timeout cycle withdraws the strobe and swallows any coincident ack.
    always_comb begin
        bus.t_adr   = '0;
        bus.t_dat_w = '0;
        bus.t_sel   = '0;
        bus.t_cyc   = 1'b0;
        bus.t_stb   = 1'b0;
        bus.t_we    = 1'b0;
        bus.i_ack   = '0;
        bus.i_err   = '0;
        if (state == OWNED) begin
            bus.t_adr       = bus.i_adr[gidx*AW +: AW];
            bus.t_dat_w     = bus.i_dat_w[gidx*DW +: DW];
            bus.t_sel       = bus.i_sel[gidx*SW +: SW];
            bus.t_cyc       = bus.i_cyc[gidx];
            bus.t_stb       = bus.i_stb[gidx] & ~tmo_err;
            bus.t_we        = bus.i_we[gidx];
            bus.i_ack[gidx] = bus.t_ack & ~tmo_err;
            bus.i_err[gidx] = bus.t_err | tmo_err;
        end
    end

    assign bus.i_dat_r = {N{bus.t_dat_r}};
endmodule
